// File: rtl/vend_dispatch_ctrl.sv
// vend_dispatch_ctrl: arbitrates buy requests, sequences dispense/change/credit-clear handshakes, tracks stock
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   credit                accumulated credit from the coin FSM
//   buy_a, buy_b          buy requests, only honoured in IDLE
//   refill                reload both stock counters (IDLE, no grant that cycle)
//   motor_done            dispenser finished the current item
//   change_ack            change dispenser accepted change_amt
//   motor_a, motor_b      dispenser drive levels
//   change_req/change_amt change payout handshake, amount stable while requested
//   credit_clr            one-cycle pulse telling the coin FSM to clear credit
//   busy, sold_out_a/b, stock_a/b, fault, last_grant  status
module vend_dispatch_ctrl #(
  parameter int CW         = 4,
  parameter int PRICE_A    = 2,
  parameter int PRICE_B    = 3,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [CW-1:0]      credit,
  input  logic               buy_a,
  input  logic               buy_b,
  input  logic               refill,
  input  logic               motor_done,
  input  logic               change_ack,
  output logic               motor_a,
  output logic               motor_b,
  output logic               change_req,
  output logic [CW-1:0]      change_amt,
  output logic               credit_clr,
  output logic               busy,
  output logic               sold_out_a,
  output logic               sold_out_b,
  output logic [STOCK_W-1:0] stock_a,
  output logic [STOCK_W-1:0] stock_b,
  output logic               fault,
  output logic               last_grant
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, DISPENSE, CHANGE, CLEAR, FAULT} state_t;
  state_t state_q, state_d;
  logic prod_q, prod_d, last_q, last_d, fault_q, fault_d;
  logic [CW-1:0] chg_q, chg_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [STOCK_W-1:0] stock_a_q, stock_a_d, stock_b_q, stock_b_d;
  logic motor_a_q, motor_b_q, change_req_q, clr_q;
  logic elig_a, elig_b, gsel;
  assign elig_a = buy_a && credit >= CW'(PRICE_A) && stock_a_q != '0;
  assign elig_b = buy_b && credit >= CW'(PRICE_B) && stock_b_q != '0;
  // gsel: 1 selects B; on a tie the product not served last wins
  assign gsel = (elig_a && elig_b) ? !last_q : elig_b;
  always_comb begin
    state_d   = state_q;
    prod_d    = prod_q;
    chg_d     = chg_q;
    timer_d   = timer_q;
    stock_a_d = stock_a_q;
    stock_b_d = stock_b_q;
    last_d    = last_q;
    fault_d   = fault_q;
    case (state_q)
      IDLE: begin
        if (elig_a || elig_b) begin
          state_d = DISPENSE;
          prod_d  = gsel;
          chg_d   = credit - (gsel ? CW'(PRICE_B) : CW'(PRICE_A));
          timer_d = '0;
        end else if (refill) begin
          stock_a_d = STOCK_W'(STOCK_INIT);
          stock_b_d = STOCK_W'(STOCK_INIT);
        end
      end
      DISPENSE: begin
        // motor_done on the last allowed cycle still counts as a successful vend
        if (motor_done) begin
          state_d   = chg_q != '0 ? CHANGE : CLEAR;
          last_d    = prod_q;
          stock_a_d = prod_q ? stock_a_q : stock_a_q - STOCK_W'(1);
          stock_b_d = prod_q ? stock_b_q - STOCK_W'(1) : stock_b_q;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      CHANGE:  state_d = change_ack ? CLEAR : CHANGE;
      CLEAR:   state_d = IDLE;
      default: state_d = FAULT;
    endcase
  end
  // handshake outputs are flopped from the next state so they are glitch-free Moore levels
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      prod_q       <= 1'b0;
      chg_q        <= '0;
      timer_q      <= '0;
      stock_a_q    <= STOCK_W'(STOCK_INIT);
      stock_b_q    <= STOCK_W'(STOCK_INIT);
      last_q       <= 1'b1;
      fault_q      <= 1'b0;
      motor_a_q    <= 1'b0;
      motor_b_q    <= 1'b0;
      change_req_q <= 1'b0;
      clr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      prod_q       <= prod_d;
      chg_q        <= chg_d;
      timer_q      <= timer_d;
      stock_a_q    <= stock_a_d;
      stock_b_q    <= stock_b_d;
      last_q       <= last_d;
      fault_q      <= fault_d;
      motor_a_q    <= state_d == DISPENSE && !prod_d;
      motor_b_q    <= state_d == DISPENSE && prod_d;
      change_req_q <= state_d == CHANGE;
      clr_q        <= state_d == CLEAR;
    end
  end
  assign motor_a    = motor_a_q;
  assign motor_b    = motor_b_q;
  assign change_req = change_req_q;
  assign change_amt = chg_q;
  assign credit_clr = clr_q;
  assign busy       = state_q != IDLE;
  assign sold_out_a = stock_a_q == '0;
  assign sold_out_b = stock_b_q == '0;
  assign stock_a    = stock_a_q;
  assign stock_b    = stock_b_q;
  assign fault      = fault_q;
  assign last_grant = last_q;
endmodule

// File: tb/tb_vend_dispatch_ctrl.sv
// tb_vend_dispatch_ctrl: scoreboard-driven bench for vend_dispatch_ctrl
module tb_vend_dispatch_ctrl;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [3:0] credit = '0;
  logic buy_a = 1'b0, buy_b = 1'b0, refill = 1'b0, motor_done = 1'b0, change_ack = 1'b0;
  logic motor_a, motor_b, change_req, credit_clr, busy, sold_out_a, sold_out_b, fault, last_grant;
  logic [3:0] change_amt, stock_a, stock_b;
  int total = 0, bad = 0;
  typedef struct packed {logic prod_b; logic [3:0] chg;} exp_t;
  exp_t exp_q[$];
  exp_t cur = '0;
  logic in_txn = 1'b0, saw_chg = 1'b0, pm = 1'b0;

  vend_dispatch_ctrl dut (
    .clk(clk), .reset_n(reset_n), .credit(credit), .buy_a(buy_a), .buy_b(buy_b),
    .refill(refill), .motor_done(motor_done), .change_ack(change_ack),
    .motor_a(motor_a), .motor_b(motor_b), .change_req(change_req), .change_amt(change_amt),
    .credit_clr(credit_clr), .busy(busy), .sold_out_a(sold_out_a), .sold_out_b(sold_out_b),
    .stock_a(stock_a), .stock_b(stock_b), .fault(fault), .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset_n) begin
      in_txn = 1'b0;
      saw_chg = 1'b0;
      exp_q.delete();
    end else begin
      if ((motor_a || motor_b) && !pm) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_vend motor_a=%0b motor_b=%0b with nothing queued", motor_a, motor_b);
        end else begin
          cur = exp_q.pop_front();
          in_txn = 1'b1;
          saw_chg = 1'b0;
          if ({motor_b, motor_a} !== (cur.prod_b ? 2'b10 : 2'b01)) begin
            bad++;
            $display("FAIL vend_product motor_b,motor_a=%b want=%b", {motor_b, motor_a}, cur.prod_b ? 2'b10 : 2'b01);
          end
        end
      end
      if (change_req) begin
        total++;
        saw_chg = 1'b1;
        if (!in_txn || cur.chg == 4'd0 || change_amt !== cur.chg) begin
          bad++;
          $display("FAIL change_amt got=%0d want=%0d in_txn=%0b", change_amt, cur.chg, in_txn);
        end
      end
      if (credit_clr) begin
        total++;
        if (!in_txn || saw_chg !== (cur.chg != 4'd0)) begin
          bad++;
          $display("FAIL credit_clr in_txn=%0b saw_change=%0b want_change=%0b", in_txn, saw_chg, cur.chg != 4'd0);
        end
        in_txn = 1'b0;
      end
    end
    pm = motor_a || motor_b;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic vend(input logic a, input logic b, input logic [3:0] cr, input logic exp_b,
                      input int d, input logic rf);
    exp_t e;
    e.prod_b = exp_b;
    e.chg = cr - (exp_b ? 4'd3 : 4'd2);
    exp_q.push_back(e);
    credit = cr; buy_a = a; buy_b = b; refill = rf;
    cyc();
    buy_a = 1'b0; buy_b = 1'b0; refill = 1'b0;
    repeat (d) cyc();
    motor_done = 1'b1;
    cyc();
    motor_done = 1'b0;
    if (e.chg != 4'd0) begin
      change_ack = 1'b1;
      cyc();
      change_ack = 1'b0;
    end
    cyc();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
    total++; if ({motor_a, motor_b, change_req, credit_clr, fault, busy} !== 6'b0) begin bad++; $display("FAIL reset_outputs got=%b want=000000", {motor_a, motor_b, change_req, credit_clr, fault, busy}); end
    total++; if (stock_a !== 4'd8 || stock_b !== 4'd8) begin bad++; $display("FAIL reset_stock got=%0d,%0d want=8,8", stock_a, stock_b); end
    total++; if (last_grant !== 1'b1) begin bad++; $display("FAIL reset_last_grant got=%b want=1", last_grant); end
    total++; if (change_amt !== 4'd0 || sold_out_a !== 1'b0 || sold_out_b !== 1'b0) begin bad++; $display("FAIL reset_misc amt=%0d so=%b%b want 0,00", change_amt, sold_out_a, sold_out_b); end
  endtask

  task automatic test_basic();
    exp_t e;
    e.prod_b = 1'b0; e.chg = 4'd3;
    exp_q.push_back(e);
    credit = 4'd5; buy_a = 1'b1;
    cyc();
    buy_a = 1'b0;
    total++; if (motor_a !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL motor_latency motor_a=%b busy=%b want 1,1", motor_a, busy); end
    repeat (2) cyc();
    motor_done = 1'b1;
    cyc();
    motor_done = 1'b0;
    total++; if (motor_a !== 1'b0 || change_req !== 1'b1 || change_amt !== 4'd3) begin bad++; $display("FAIL change_phase motor_a=%b req=%b amt=%0d want 0,1,3", motor_a, change_req, change_amt); end
    total++; if (stock_a !== 4'd7) begin bad++; $display("FAIL basic_stock got=%0d want=7", stock_a); end
    cyc();
    total++; if (change_req !== 1'b1 || credit_clr !== 1'b0) begin bad++; $display("FAIL change_hold req=%b clr=%b want 1,0", change_req, credit_clr); end
    change_ack = 1'b1;
    cyc();
    change_ack = 1'b0;
    total++; if (credit_clr !== 1'b1 || change_req !== 1'b0) begin bad++; $display("FAIL clr_pulse clr=%b req=%b want 1,0", credit_clr, change_req); end
    cyc();
    total++; if (credit_clr !== 1'b0 || busy !== 1'b0 || last_grant !== 1'b0) begin bad++; $display("FAIL basic_end clr=%b busy=%b last=%b want 0,0,0", credit_clr, busy, last_grant); end
  endtask

  task automatic test_tie();
    vend(1'b1, 1'b1, 4'd4, 1'b1, 1, 1'b0);
    total++; if (last_grant !== 1'b1 || stock_b !== 4'd7) begin bad++; $display("FAIL tie_b last=%b stock_b=%0d want 1,7", last_grant, stock_b); end
    vend(1'b1, 1'b1, 4'd4, 1'b0, 1, 1'b0);
    total++; if (last_grant !== 1'b0 || stock_a !== 4'd6) begin bad++; $display("FAIL tie_a last=%b stock_a=%0d want 0,6", last_grant, stock_a); end
  endtask

  task automatic test_reject();
    credit = 4'd2; buy_b = 1'b1;
    cyc();
    buy_b = 1'b0;
    total++; if (busy !== 1'b0 || motor_b !== 1'b0) begin bad++; $display("FAIL reject_low_credit busy=%b motor_b=%b want 0,0", busy, motor_b); end
    vend(1'b0, 1'b1, 4'd3, 1'b1, 0, 1'b0);
    total++; if (stock_b !== 4'd6 || busy !== 1'b0 || last_grant !== 1'b1) begin bad++; $display("FAIL exact_credit stock_b=%0d busy=%b last=%b want 6,0,1", stock_b, busy, last_grant); end
  endtask

  task automatic test_stock();
    for (int i = 0; i < 6; i++) vend(1'b1, 1'b0, 4'd2, 1'b0, 0, 1'b0);
    total++; if (stock_a !== 4'd0 || sold_out_a !== 1'b1) begin bad++; $display("FAIL sold_out stock_a=%0d so=%b want 0,1", stock_a, sold_out_a); end
    credit = 4'd5; buy_a = 1'b1;
    cyc();
    buy_a = 1'b0;
    total++; if (busy !== 1'b0 || stock_a !== 4'd0) begin bad++; $display("FAIL empty_buy busy=%b stock_a=%0d want 0,0", busy, stock_a); end
    refill = 1'b1;
    cyc();
    refill = 1'b0;
    total++; if (stock_a !== 4'd8 || stock_b !== 4'd8 || sold_out_a !== 1'b0) begin bad++; $display("FAIL refill got=%0d,%0d so=%b want 8,8,0", stock_a, stock_b, sold_out_a); end
    vend(1'b0, 1'b1, 4'd3, 1'b1, 0, 1'b0);
    vend(1'b1, 1'b0, 4'd2, 1'b0, 0, 1'b1);
    total++; if (stock_a !== 4'd7 || stock_b !== 4'd7) begin bad++; $display("FAIL refill_dropped got=%0d,%0d want 7,7", stock_a, stock_b); end
  endtask

  task automatic test_timeout_edge();
    vend(1'b1, 1'b0, 4'd2, 1'b0, 15, 1'b0);
    total++; if (fault !== 1'b0 || stock_a !== 4'd6 || busy !== 1'b0) begin bad++; $display("FAIL late_done fault=%b stock_a=%0d busy=%b want 0,6,0", fault, stock_a, busy); end
  endtask

  task automatic test_fault();
    exp_t e;
    e.prod_b = 1'b0; e.chg = 4'd3;
    exp_q.push_back(e);
    credit = 4'd5; buy_a = 1'b1;
    cyc();
    buy_a = 1'b0;
    repeat (15) cyc();
    total++; if (fault !== 1'b0 || motor_a !== 1'b1) begin bad++; $display("FAIL pre_timeout fault=%b motor_a=%b want 0,1", fault, motor_a); end
    cyc();
    total++; if (fault !== 1'b1 || motor_a !== 1'b0 || busy !== 1'b1 || stock_a !== 4'd6) begin bad++; $display("FAIL timeout fault=%b motor_a=%b busy=%b stock_a=%0d want 1,0,1,6", fault, motor_a, busy, stock_a); end
    buy_a = 1'b1; buy_b = 1'b1; refill = 1'b1; motor_done = 1'b1; change_ack = 1'b1;
    repeat (4) cyc();
    buy_a = 1'b0; buy_b = 1'b0; refill = 1'b0; motor_done = 1'b0; change_ack = 1'b0;
    total++; if (fault !== 1'b1 || busy !== 1'b1 || {motor_a, motor_b, change_req, credit_clr} !== 4'b0) begin bad++; $display("FAIL fault_sticky fault=%b busy=%b outs=%b want 1,1,0000", fault, busy, {motor_a, motor_b, change_req, credit_clr}); end
    total++; if (stock_a !== 4'd6 || stock_b !== 4'd7) begin bad++; $display("FAIL fault_stock got=%0d,%0d want 6,7", stock_a, stock_b); end
    reset_n = 1'b0;
    #1;
    total++; if (fault !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL fault_reset fault=%b busy=%b want 0,0", fault, busy); end
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    e.prod_b = 1'b0; e.chg = 4'd3;
    exp_q.push_back(e);
    credit = 4'd5; buy_a = 1'b1;
    cyc();
    buy_a = 1'b0;
    motor_done = 1'b1;
    cyc();
    motor_done = 1'b0;
    cyc();
    total++; if (change_req !== 1'b1 || stock_a !== 4'd7) begin bad++; $display("FAIL mid_setup req=%b stock_a=%0d want 1,7", change_req, stock_a); end
    reset_n = 1'b0;
    #1;
    total++; if (change_req !== 1'b0 || busy !== 1'b0 || stock_a !== 4'd8) begin bad++; $display("FAIL async_reset req=%b busy=%b stock_a=%0d want 0,0,8", change_req, busy, stock_a); end
    cyc();
    reset_n = 1'b1;
    cyc();
    total++; if (busy !== 1'b0 || stock_b !== 4'd8 || last_grant !== 1'b1 || credit_clr !== 1'b0) begin bad++; $display("FAIL post_reset busy=%b stock_b=%0d last=%b clr=%b want 0,8,1,0", busy, stock_b, last_grant, credit_clr); end
  endtask

  task automatic test_back_to_back();
    vend(1'b1, 1'b1, 4'd5, 1'b0, 0, 1'b0);
    vend(1'b1, 1'b1, 4'd5, 1'b1, 0, 1'b0);
    vend(1'b1, 1'b1, 4'd5, 1'b0, 0, 1'b0);
    total++; if (stock_a !== 4'd6 || stock_b !== 4'd7 || last_grant !== 1'b0) begin bad++; $display("FAIL back_to_back got=%0d,%0d last=%b want 6,7,0", stock_a, stock_b, last_grant); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_reject();
    test_stock();
    test_timeout_edge();
    test_fault();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vend_dispatch_ctrl.md
Name: vend_dispatch_ctrl

Overview:
Sequencer between the coin/credit FSM and the vending mechanics. It takes buy requests for products A and B and checks credit and stock. It arbitrates simultaneous requests round-robin, drives the dispense motor handshake, then the change-return handshake, and finally pulses a credit clear back to the coin FSM. It keeps per-product stock counters and flags a sticky fault on a motor timeout.

Parameters:
CW, 4, credit/change width
PRICE_A, 2, price of product A in credit units
PRICE_B, 3, price of product B in credit units
STOCK_W, 4, stock counter width
STOCK_INIT, 8, stock value after reset/refill
TIMEOUT, 16, max cycles in DISPENSE waiting for motor_done

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
credit  in  CW  current accumulated credit from coin FSM
buy_a  in  1  buy request product A (sampled in IDLE only)
buy_b  in  1  buy request product B (sampled in IDLE only)
refill  in  1  reload both stock counters to STOCK_INIT
motor_done  in  1  dispenser finished current item
change_ack  in  1  change dispenser accepted change_amt
motor_a  out  1  drive dispenser A, level
motor_b  out  1  drive dispenser B, level
change_req  out  1  request change payout, level
change_amt  out  CW  change value, stable while change_req=1
credit_clr  out  1  one-cycle pulse: coin FSM clears credit
busy  out  1  state != IDLE
sold_out_a  out  1  stock_a == 0
sold_out_b  out  1  stock_b == 0
stock_a  out  STOCK_W  remaining stock A
stock_b  out  STOCK_W  remaining stock B
fault  out  1  sticky motor-timeout flag
last_grant  out  1  0=A, 1=B last served

Behaviour:
- Reset (async, reset_n=0): state IDLE; all motor/change/clr/fault outputs 0; change_amt 0; stock_a=stock_b=STOCK_INIT; last_grant=1, so A wins the first tie. Applies mid-operation; outputs drop immediately.
- All handshake outputs are registered (Moore); sold_out_x and busy are decoded from registers.
- States: IDLE, DISPENSE, CHANGE, CLEAR, FAULT.
- IDLE: elig_a = buy_a && credit>=PRICE_A && stock_a!=0; elig_b likewise with PRICE_B/stock_b.
  - One eligible: grant it.
  - Both eligible: grant the product != last_grant.
  - On grant: latch product; latch chg = credit - price (CW bits, never negative); go to DISPENSE.
  - Ineligible requests are silently dropped; no output change.
  - refill with no grant that cycle: both stocks = STOCK_INIT next cycle. A grant takes priority and the refill is dropped.
- DISPENSE: motor_x=1 from cycle after grant (latency 1). Timer starts at 0 on entry and increments each cycle.
  - On motor_done: next cycle motor_x=0; stock_x decrements; last_grant=x; go to CHANGE if chg!=0, else CLEAR.
  - Timer reaches TIMEOUT-1 without motor_done that cycle: fault=1, motor_x=0, go to FAULT. Stock and credit are untouched.
  - motor_done on the timeout cycle counts as success.
- CHANGE: change_req=1, change_amt=chg held stable. On change_ack=1: change_req=0 next cycle, go to CLEAR. No timeout.
- CLEAR: credit_clr=1 for exactly one cycle, then IDLE. credit_clr never fires on rejected buys or faults.
- FAULT: terminal until reset; busy=1; all buys, refill and handshake inputs ignored.
- Outside their states, motor_done, change_ack, buy_x and refill are ignored.
- Stock never wraps: eligibility blocks any vend at 0.

Test Plan:
1. Reset, credit=5, buy_a pulse → motor_a=1 next cycle; motor_done 3 cycles later → change_req=1, change_amt=3; change_ack → credit_clr pulse 1 cycle, stock_a=7, busy=0.
2. credit=4, buy_a&buy_b same cycle → A served (change 2). Repeat tie → B served (change 1), last_grant=1.
3. credit=2, buy_b → no response, busy stays 0. Then credit=3, buy_b → after motor_done go straight to credit_clr, change_req never asserts.
4. Eight A vends → stock_a=0, sold_out_a=1, ninth buy_a ignored. refill in IDLE → stock_a=8, sold_out_a=0. refill together with an eligible buy → refill dropped.
5. buy_a, hold motor_done=0 for 16 cycles → fault=1, motor_a=0, stock_a unchanged, no credit_clr, later buys ignored. reset_n low clears fault.
6. Assert reset_n=0 mid-CHANGE → change_req=0 immediately; after release state IDLE, stocks=8.
